// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial pattern detector. Accepted bits shift into a PAT_W-bit history.
//   A match fires once at least PAT_W bits have been accepted since reset or
//   since the last non-overlapping restart, and the history equals PATTERN.
//   Each match gives a one-cycle registered pulse on z and bumps a
//   saturating match counter.
//
// Ports
//   clk          in   clock; all state updates on the rising edge
//   reset        in   synchronous active-high reset
//   x            in   serial data bit
//   x_valid      in   x is accepted on an edge only when high
//   overlap_mode in   1 = overlapping detection, 0 = non-overlapping
//   clear_cnt    in   synchronous clear of match_count
//   z            out  registered match pulse, one cycle per match
//   match_count  out  saturating number of matches since reset or clear
//   cnt_full     out  high while match_count is at its maximum value
module seq_detect_param #(
  parameter int                PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter int                CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap_mode,
  input  logic             clear_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_full
);

  // fill counts 0..PAT_W, so it needs enough bits to hold PAT_W itself.
  localparam int                FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;

  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic              match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Candidate next state for an accepted bit. The fill gate keeps the
  // all-zero reset history from matching an all-zero PATTERN.
  always_comb begin
    hist_n = (hist << 1) | PAT_W'(x);
    fill_n = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
    match  = x_valid && (fill_n == FILL_MAX) && (hist_n == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist        <= '0;
      fill        <= '0;
      z           <= 1'b0;
      match_count <= '0;
    end else begin
      z <= match;
      if (x_valid) begin
        hist <= hist_n;
        // A non-overlapping match restarts the fill so the next match needs
        // PAT_W fresh bits; the stale history is then gated by fill.
        if (match && !overlap_mode)
          fill <= '0;
        else
          fill <= fill_n;
      end
      if (match)
        match_count <= clear_cnt ? CNT_W'(1) : sat_inc(match_count);
      else if (clear_cnt)
        match_count <= '0;
    end
  end

  assign cnt_full = (match_count == CNT_MAX);

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 4, pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011, target sequence of width PAT_W; the MSB is the oldest bit and the LSB is the newest bit.
REQ-003 Parameter CNT_W, default 8, match counter width; legal range 1..16.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 x  input  1  serial data bit.
REQ-007 x_valid  input  1  x is accepted on a rising edge only when x_valid=1.
REQ-008 overlap_mode  input  1  1=overlapping detection, 0=non-overlapping detection; sampled with each accepted bit.
REQ-009 clear_cnt  input  1  synchronous clear of match_count.
REQ-010 z  output  1  registered match pulse.
REQ-011 match_count  output  CNT_W  number of matches since reset or clear, saturating.
REQ-012 cnt_full  output  1  high while match_count equals 2^CNT_W-1.

Function
REQ-013 Internal state SHALL be a PAT_W-bit history register (hist) and a fill counter (fill, range 0..PAT_W).
REQ-014 Accepted bit, next-state values: hist_n={hist[PAT_W-2:0],x}; fill_n=min(fill+1,PAT_W).
REQ-015 A match SHALL occur on an accepted bit if and only if fill_n==PAT_W and hist_n==PATTERN.
REQ-016 A match SHALL NOT occur until PAT_W bits have been accepted since reset or since the last non-overlap restart.
  - Consequence: the reset-zero history never produces a false match, including when PATTERN is all-zero.
REQ-017 On a match with overlap_mode=1: hist<=hist_n and fill<=PAT_W, so a suffix of the matched bits can start the next match.
REQ-018 On a match with overlap_mode=0: fill<=0, so the next match needs PAT_W fresh accepted bits.
REQ-019 On an accepted bit with no match: hist<=hist_n and fill<=fill_n.
REQ-020 x_valid=0 SHALL leave hist, fill and match_count unchanged and SHALL drive z to 0 on that edge.
REQ-021 z SHALL be 1 for exactly the one cycle after the edge on which the matching bit is accepted, and 0 otherwise.
  - Latency: 1 cycle from the completing bit.
  - Back-to-back matches give back-to-back z pulses.
REQ-022 match_count SHALL increment by 1 on each match and saturate at 2^CNT_W-1; it SHALL never wrap.
REQ-023 clear_cnt=1 with no match SHALL set match_count<=0.
REQ-024 clear_cnt=1 on the same edge as a match SHALL set match_count<=1 and z<=1.
REQ-025 clear_cnt SHALL NOT affect hist, fill or z.
REQ-026 A change of overlap_mode SHALL take effect on the next accepted bit; history already accumulated is kept.
REQ-027 cnt_full SHALL be derived combinationally from match_count.

Reset
REQ-028 reset=1 at a rising edge SHALL set hist=0, fill=0, z=0 and match_count=0, with cnt_full=0.
REQ-029 reset SHALL have priority over x_valid, clear_cnt and any match on the same edge.
REQ-030 A reset mid-pattern SHALL discard all partial progress.

Verification (PATTERN=4'b1011, CNT_W=8 unless stated)
REQ-031 overlap_mode=1, x_valid=1, bits 1,0,1,1,0,1,1 -> z pulses after bit 4 and after bit 7; match_count=2.
REQ-032 overlap_mode=0, same 7 bits -> z pulses after bit 4 only, count=1.
  - Then bits 1,0,1,1 -> second pulse after bit 11; count=2.
REQ-033 overlap_mode=1, bits 1,0,1,1 with x_valid=0 gap cycles between every bit (x toggling during gaps) -> one pulse after the 4th valid bit; no pulses in gap cycles.
REQ-034 Bits 1,0,1, then reset, then 1,0,1,1 -> no pulse before the final bit, pulse after the final bit; count=1.
  - With PATTERN=4'b0000: four cycles of x=0 immediately after reset -> pulse only after the 4th bit.
REQ-035 CNT_W=2, overlap_mode=1, stream of 8 consecutive 1s with PATTERN=4'b1111 -> 5 pulses; count=3, cnt_full=1.
  - Then clear_cnt=1 on an edge with no match -> count=0, cnt_full=0.
  - Then clear_cnt=1 coincident with a match -> count=1.
